// File: rtl/alu_stream_core.sv
// Byte-stream ALU: opcode, A, B in (MSB first), WIDTH-bit result out, iterative MUL/DIV.
// Optional macro ALU_STATUS_EN appends a {5'b0, div0, borrow, carry} status byte to each result.
module alu_stream_core #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err_div0,
  output logic       err_op
);

  localparam int NBYTES = WIDTH / 8;
`ifdef ALU_STATUS_EN
  localparam int OBYTES = NBYTES + 1;
`else
  localparam int OBYTES = NBYTES;
`endif
  localparam int OBW = OBYTES * 8;
  localparam logic [5:0] LAST_BYTE = 6'(NBYTES - 1);
  localparam logic [5:0] OUT_LAST  = 6'(OBYTES - 1);
  localparam logic [5:0] ITERS     = 6'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL_LO = 3'd2,
                         OP_MUL_HI = 3'd3, OP_DIV_Q = 3'd4, OP_DIV_R = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_SEND} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [5:0]         cnt_q;
  logic [OBW-1:0]     out_buf_q;
  logic               in_ready_q, out_valid_q, busy_q, err_div0_q, err_op_q;
  logic [7:0]         out_data_q;

  logic [WIDTH-1:0]   add_d, sub_d, rem_d, res_d;
  logic [WIDTH:0]     mul_sum_d, r_sh_d;
  logic [2*WIDTH-1:0] mul_d, div_d;
  logic               ge_d, is_div_d, div0_d, exec_done_d;
  logic [OBW-1:0]     frame_d;

  // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    add_d       = a_q + b_q;
    sub_d       = a_q - b_q;
    mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_d       = {mul_sum_d, acc_q[WIDTH-1:1]};
    r_sh_d      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge_d        = r_sh_d >= {1'b0, b_q};
    rem_d       = ge_d ? WIDTH'(r_sh_d - {1'b0, b_q}) : r_sh_d[WIDTH-1:0];
    div_d       = {rem_d, acc_q[WIDTH-2:0], ge_d};
    is_div_d    = (op_q == OP_DIV_Q) || (op_q == OP_DIV_R);
    div0_d      = is_div_d && (b_q == '0);
    exec_done_d = div0_d || (cnt_q == 6'd1);
    case (op_q)
      OP_ADD:    res_d = add_d;
      OP_SUB:    res_d = sub_d;
      OP_MUL_LO: res_d = mul_d[WIDTH-1:0];
      OP_MUL_HI: res_d = mul_d[2*WIDTH-1:WIDTH];
      OP_DIV_Q:  res_d = div0_d ? '1 : div_d[WIDTH-1:0];
      OP_DIV_R:  res_d = div0_d ? a_q : div_d[2*WIDTH-1:WIDTH];
      default:   res_d = '0;
    endcase
`ifdef ALU_STATUS_EN
    frame_d = {res_d, 5'b0, div0_d, (op_q == OP_SUB) && (a_q < b_q),
               (op_q == OP_ADD) && (add_d < a_q)};
`else
    frame_d = res_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_buf_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      err_div0_q  <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      err_op_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (in_data[2:0] > OP_DIV_R) begin
              err_op_q <= 1'b1;
            end else begin
              op_q       <= in_data[2:0];
              busy_q     <= 1'b1;
              err_div0_q <= 1'b0;
              cnt_q      <= LAST_BYTE;
              state_q    <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (in_valid && in_ready_q) begin
            a_q <= (a_q << 8) | WIDTH'(in_data);
            if (cnt_q == '0) begin
              cnt_q   <= LAST_BYTE;
              state_q <= S_LOAD_B;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        S_LOAD_B: begin
          if (in_valid && in_ready_q) begin
            b_q <= (b_q << 8) | WIDTH'(in_data);
            if (cnt_q == '0) begin
              in_ready_q <= 1'b0;
              acc_q      <= {{WIDTH{1'b0}}, a_q};
              cnt_q      <= (op_q >= OP_MUL_LO) ? ITERS : 6'd1;
              state_q    <= S_EXEC;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end
        S_EXEC: begin
          if (op_q == OP_MUL_LO || op_q == OP_MUL_HI) acc_q <= mul_d;
          else if (is_div_d) acc_q <= div_d;
          cnt_q <= cnt_q - 6'd1;
          if (exec_done_d) begin
            out_buf_q  <= frame_d;
            err_div0_q <= err_div0_q | div0_d;
            cnt_q      <= OUT_LAST;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          // first byte is loaded one cycle after EXEC; later bytes follow each accept
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_buf_q[OBW-1 -: 8];
            out_buf_q   <= out_buf_q << 8;
          end else if (out_ready) begin
            if (cnt_q == '0) begin
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              out_data_q <= out_buf_q[OBW-1 -: 8];
              out_buf_q  <= out_buf_q << 8;
              cnt_q      <= cnt_q - 6'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err_div0  = err_div0_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_alu_stream_core.sv
// Directed bench for alu_stream_core at WIDTH=16; status-byte checks follow ALU_STATUS_EN.
module tb_alu_stream_core;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy, err_div0, err_op;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_stream_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err_div0(err_div0), .err_op(err_op)
  );

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL recv_timeout: out_valid=%0b required 1", out_valid);
    end
    b = out_data;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    send_byte(op);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b[15:8]);
    send_byte(b[7:0]);
  endtask

  task automatic recv_word(output logic [15:0] r);
    logic [7:0] hi, lo;
    recv_byte(hi);
    recv_byte(lo);
    r = {hi, lo};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: in_ready=%0b out_valid=%0b busy=%0b required 0 0 0",
               in_ready, out_valid, busy);
    end
    total++;
    if (out_data !== 8'h00 || err_div0 !== 1'b0 || err_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: out_data=%h err_div0=%0b err_op=%0b required 00 0 0",
               out_data, err_div0, err_op);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [7:0] b0, b1;
    logic [15:0] r;
    send_byte(8'h00);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL add_busy_start: busy=%0b required 1", busy);
    end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h0F); send_byte(8'hF0);
    recv_byte(b0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL add_busy_mid: busy=%0b required 1", busy);
    end
    recv_byte(b1);
    total++;
    if ({b0, b1} !== 16'h2224) begin
      bad++; $display("FAIL add_result: got %h required 2224", {b0, b1});
    end
`ifdef ALU_STATUS_EN
    recv_byte(b0);
    total++;
    if (b0 !== 8'h00) begin
      bad++; $display("FAIL add_status: got %h required 00", b0);
    end
`endif
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL add_busy_end: busy=%0b in_ready=%0b required 0 1", busy, in_ready);
    end
    send_cmd(8'h00, 16'hFFFF, 16'h0001);
    recv_word(r);
    total++;
    if (r !== 16'h0000) begin
      bad++; $display("FAIL add_wrap: got %h required 0000", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(b0);
    total++;
    if (b0 !== 8'h01) begin
      bad++; $display("FAIL add_carry_status: got %h required 01", b0);
    end
`endif
  endtask

  task automatic test_sub();
    logic [15:0] r;
    logic [7:0] s;
    send_cmd(8'h01, 16'h0001, 16'h0002);
    recv_word(r);
    total++;
    if (r !== 16'hFFFF) begin
      bad++; $display("FAIL sub_borrow: got %h required ffff", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
    total++;
    if (s !== 8'h02) begin
      bad++; $display("FAIL sub_status: got %h required 02", s);
    end
`endif
    send_cmd(8'h01, 16'h5000, 16'h1234);
    recv_word(r);
    total++;
    if (r !== 16'h3DCC) begin
      bad++; $display("FAIL sub_plain: got %h required 3dcc", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
  endtask

  task automatic test_mul();
    logic [15:0] r;
    logic [7:0] s;
    int n;
    send_cmd(8'h02, 16'h1234, 16'h0100);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != W + 1) begin
      bad++; $display("FAIL mul_latency: got %0d cycles required %0d", n, W + 1);
    end
    recv_word(r);
    total++;
    if (r !== 16'h3400) begin
      bad++; $display("FAIL mul_lo: got %h required 3400", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
    send_cmd(8'h03, 16'h1234, 16'h0100);
    recv_word(r);
    total++;
    if (r !== 16'h0012) begin
      bad++; $display("FAIL mul_hi: got %h required 0012", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
    send_cmd(8'h03, 16'hFFFF, 16'hFFFF);
    recv_word(r);
    total++;
    if (r !== 16'hFFFE) begin
      bad++; $display("FAIL mul_hi_max: got %h required fffe", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
  endtask

  task automatic test_div();
    logic [15:0] r;
    logic [7:0] s;
    int n;
    send_cmd(8'h04, 16'h03E8, 16'h0007);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n != W + 1) begin
      bad++; $display("FAIL div_latency: got %0d cycles required %0d", n, W + 1);
    end
    recv_word(r);
    total++;
    if (r !== 16'h008E) begin
      bad++; $display("FAIL div_q: got %h required 008e", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
    send_cmd(8'h05, 16'h03E8, 16'h0007);
    recv_word(r);
    total++;
    if (r !== 16'h0006) begin
      bad++; $display("FAIL div_r: got %h required 0006", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
    send_cmd(8'h04, 16'h0500, 16'h0000);
    recv_word(r);
    total++;
    if (r !== 16'hFFFF || err_div0 !== 1'b1) begin
      bad++; $display("FAIL div0_q: got %h err_div0=%0b required ffff 1", r, err_div0);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
    total++;
    if (s !== 8'h04) begin
      bad++; $display("FAIL div0_status: got %h required 04", s);
    end
`endif
    send_cmd(8'h05, 16'h0500, 16'h0000);
    recv_word(r);
    total++;
    if (r !== 16'h0500 || err_div0 !== 1'b1) begin
      bad++; $display("FAIL div0_r: got %h err_div0=%0b required 0500 1", r, err_div0);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
    send_byte(8'h00);
    total++;
    if (err_div0 !== 1'b0) begin
      bad++; $display("FAIL div0_clear: err_div0=%0b required 0", err_div0);
    end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    recv_word(r);
    total++;
    if (r !== 16'h0002) begin
      bad++; $display("FAIL div0_next_add: got %h required 0002", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] b0, b1, held;
    logic stable;
    int n;
    send_cmd(8'h00, 16'h1234, 16'h1111);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    held = out_data;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1 || held !== 8'h23) begin
      bad++; $display("FAIL bp_first_hold: byte=%h stable=%0b required 23 1", held, stable);
    end
    recv_byte(b0);
    held = out_data;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1 || held !== 8'h45) begin
      bad++; $display("FAIL bp_mid_hold: byte=%h stable=%0b required 45 1", held, stable);
    end
    recv_byte(b1);
    total++;
    if ({b0, b1} !== 16'h2345) begin
      bad++; $display("FAIL bp_result: got %h required 2345", {b0, b1});
    end
`ifdef ALU_STATUS_EN
    recv_byte(b0);
`endif
  endtask

  task automatic test_illegal();
    logic [15:0] r;
    logic [7:0] s;
    logic seen;
    in_data = 8'h07;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (err_op !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_07: err_op=%0b busy=%0b in_ready=%0b required 1 0 1",
                      err_op, busy, in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (err_op !== 1'b0) begin
      bad++; $display("FAIL illegal_pulse: err_op=%0b required 0", err_op);
    end
    in_data = 8'h0E;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    total++;
    if (err_op !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL illegal_0e: err_op=%0b busy=%0b required 1 0", err_op, busy);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL illegal_no_out: out_valid seen=%0b required 0", seen);
    end
    send_cmd(8'hF8, 16'h0001, 16'h0002);
    recv_word(r);
    total++;
    if (r !== 16'h0003) begin
      bad++; $display("FAIL opcode_upper_ignored: got %h required 0003", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
`endif
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [7:0] s;
    logic seen;
    send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h0F);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL rst_load_b: busy=%0b in_ready=%0b out_valid=%0b out_data=%h required 0 0 0 00",
                      busy, in_ready, out_valid, out_data);
    end
    send_cmd(8'h02, 16'h1234, 16'h0100);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || err_div0 !== 1'b0 || err_op !== 1'b0) begin
      bad++; $display("FAIL rst_exec: busy=%0b in_ready=%0b out_valid=%0b err_div0=%0b err_op=%0b required 0 0 0 0 0",
                      busy, in_ready, out_valid, err_div0, err_op);
    end
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rst_exec_no_out: out_valid seen=%0b required 0", seen);
    end
    send_cmd(8'h00, 16'h1234, 16'h0FF0);
    recv_word(r);
    total++;
    if (r !== 16'h2224) begin
      bad++; $display("FAIL rst_then_add: got %h required 2224", r);
    end
`ifdef ALU_STATUS_EN
    recv_byte(s);
    total++;
    if (s !== 8'h00) begin
      bad++; $display("FAIL rst_then_add_status: got %h required 00", s);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
